// File: rtl/alu_cluster.sv
// alu_cluster: LANES independent registered ALU lanes with valid/ready handshakes,
// carry-out and branch resolution. Define ALU_CLUSTER_MUL_EN to add a per-lane
// iterative shift-add multiplier (op 1010); otherwise 1010 executes as add.
module alu_cluster #(
    parameter int XLEN  = 32,
    parameter int LANES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [LANES-1:0]      in_valid,
    output logic [LANES-1:0]      in_ready,
    input  logic [LANES*XLEN-1:0] src1,
    input  logic [LANES*XLEN-1:0] src2,
    input  logic [LANES*4-1:0]    alu_ctrl,
    input  logic [LANES*3-1:0]    funct3,
    output logic [LANES-1:0]      out_valid,
    input  logic [LANES-1:0]      out_ready,
    output logic [LANES*XLEN-1:0] result,
    output logic [LANES-1:0]      carry,
    output logic [LANES-1:0]      br_taken
);
    localparam int SHW = $clog2(XLEN);

`ifdef ALU_CLUSTER_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [XLEN-1:0] w_a, w_b, w_res, w_sra;
        logic [3:0]      w_ctrl;
        logic [2:0]      w_f3;
        logic [SHW-1:0]  w_sh;
        logic [XLEN:0]   w_sum, w_diff;
        logic            w_lts, w_ltu, w_eq, w_cy, w_br;
        logic            w_busy, w_acc, w_is_mul, w_load_s;
        logic [XLEN-1:0] r_result;
        logic            r_valid, r_carry, r_br;

        assign w_a    = src1[i*XLEN +: XLEN];
        assign w_b    = src2[i*XLEN +: XLEN];
        assign w_ctrl = alu_ctrl[i*4 +: 4];
        assign w_f3   = funct3[i*3 +: 3];
        assign w_sh   = w_b[SHW-1:0];
        assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
        // carry bit of a + ~b + 1 is set exactly when a >= b unsigned
        assign w_diff = {1'b0, w_a} + {1'b0, ~w_b} + (XLEN+1)'(1);
        assign w_sra  = XLEN'($signed(w_a) >>> w_sh);
        assign w_lts  = $signed(w_a) < $signed(w_b);
        assign w_ltu  = w_a < w_b;
        assign w_eq   = w_a == w_b;

        assign w_br = (w_f3 == 3'b000) ? w_eq  :
                      (w_f3 == 3'b001) ? !w_eq :
                      (w_f3 == 3'b100) ? w_lts :
                      (w_f3 == 3'b101) ? !w_lts :
                      (w_f3 == 3'b110) ? w_ltu :
                      (w_f3 == 3'b111) ? !w_ltu : 1'b0;

        // single-cycle result and carry; unused codes fall through to add
        always_comb begin
            w_res = w_sum[XLEN-1:0];
            w_cy  = 1'b0;
            case (w_ctrl)
                4'b0001: begin
                    w_res = w_diff[XLEN-1:0];
                    w_cy  = w_diff[XLEN];
                end
                4'b0010: w_res = w_a << w_sh;
                4'b0011: w_res = XLEN'(w_lts);
                4'b0100: w_res = XLEN'(w_ltu);
                4'b0101: w_res = w_a ^ w_b;
                4'b0110: w_res = w_a >> w_sh;
                4'b0111: w_res = w_sra;
                4'b1000: w_res = w_a | w_b;
                4'b1001: w_res = w_a & w_b;
                default: w_cy  = w_sum[XLEN];
            endcase
        end

        assign in_ready[i] = !flush && !w_busy && (!r_valid || out_ready[i]);
        assign w_acc       = in_valid[i] && in_ready[i];
        assign w_load_s    = w_acc && !w_is_mul;

`ifdef ALU_CLUSTER_MUL_EN
        state_t          r_state, w_next;
        logic [XLEN-1:0] r_mcand, r_mplier, r_prod;
        logic [SHW-1:0]  r_cnt;
        logic            r_mbr, w_load_m;

        assign w_is_mul = w_ctrl == 4'b1010;
        assign w_busy   = r_state != S_IDLE;
        assign w_load_m = r_state == S_DONE && !flush && (!r_valid || out_ready[i]);

        // multiplier state register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_state <= S_IDLE;
            else        r_state <= w_next;
        end

        // multiplier next state; DONE waits for a free output register, flush aborts
        always_comb begin
            w_next = r_state;
            case (r_state)
                S_IDLE:  if (w_acc && w_is_mul) w_next = S_MUL;
                S_MUL:   if (r_cnt == SHW'(XLEN-1)) w_next = S_DONE;
                S_DONE:  if (!r_valid || out_ready[i]) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
            if (flush) w_next = S_IDLE;
        end

        // shift-add datapath: one multiplier bit retired per cycle
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mcand  <= '0;
                r_mplier <= '0;
                r_prod   <= '0;
                r_cnt    <= '0;
                r_mbr    <= 1'b0;
            end else if (w_acc && w_is_mul) begin
                r_mcand  <= w_a;
                r_mplier <= w_b;
                r_prod   <= '0;
                r_cnt    <= '0;
                r_mbr    <= w_br;
            end else if (r_state == S_MUL) begin
                r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + SHW'(1);
            end
        end
`else
        assign w_is_mul = 1'b0;
        assign w_busy   = 1'b0;
`endif

        // output register: held under back-pressure, dropped on flush
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid  <= 1'b0;
                r_result <= '0;
                r_carry  <= 1'b0;
                r_br     <= 1'b0;
            end else if (flush) begin
                r_valid  <= 1'b0;
            end else if (w_load_s) begin
                r_valid  <= 1'b1;
                r_result <= w_res;
                r_carry  <= w_cy;
                r_br     <= w_br;
`ifdef ALU_CLUSTER_MUL_EN
            end else if (w_load_m) begin
                r_valid  <= 1'b1;
                r_result <= r_prod;
                r_carry  <= 1'b0;
                r_br     <= r_mbr;
`endif
            end else if (out_ready[i]) begin
                r_valid  <= 1'b0;
            end
        end

        assign out_valid[i]               = r_valid;
        assign result[i*XLEN +: XLEN]     = r_result;
        assign carry[i]                   = r_carry;
        assign br_taken[i]                = r_br;
    end
endmodule
